// File: rtl/clkdiv_lfsr_multi.sv
// Multi-channel programmable clock divider with a shared, seed-loadable Fibonacci LFSR.
// Each channel runs off / toggle / duty / pulse from its own PERIOD, HIGH and MODE registers.
module clkdiv_lfsr_multi #(
  parameter int                N_CH      = 2,
  parameter int                CNT_W     = 16,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'h5555,
  localparam int               AW        = (N_CH > 1) ? $clog2(N_CH) + 2 : 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  output logic [CNT_W-1:0]  cfg_rdata,
  input  logic              sync,
  input  logic              lfsr_load,
  input  logic [LFSR_W-1:0] lfsr_seed,
  input  logic              lfsr_mode,
  output logic [N_CH-1:0]   div_out,
  output logic [N_CH-1:0]   tick,
  output logic [LFSR_W-1:0] lfsr_out
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_DUTY   = 2'd2,
    MODE_PULSE  = 2'd3
  } mode_e;

  localparam logic [1:0] F_PERIOD = 2'd0;
  localparam logic [1:0] F_HIGH   = 2'd1;
  localparam logic [1:0] F_MODE   = 2'd2;

  logic [CNT_W-1:0]  period_r  [N_CH];
  logic [CNT_W-1:0]  high_r    [N_CH];
  mode_e             mode_r    [N_CH];
  logic [CNT_W-1:0]  cnt_r     [N_CH];
  logic [CNT_W-1:0]  cnt_nxt_s [N_CH];
  logic [CNT_W-1:0]  fld_val_s [N_CH];
  logic [N_CH-1:0]   run_s;
  logic [N_CH-1:0]   wrap_s;
  logic [N_CH-1:0]   tick_nxt_s;
  logic [N_CH-1:0]   sel_s;
  logic [N_CH-1:0]   wr_period_s;
  logic [N_CH-1:0]   wr_high_s;
  logic [N_CH-1:0]   wr_mode_s;
  logic [N_CH-1:0]   div_r;
  logic [N_CH-1:0]   tick_r;
  logic [AW-1:0]     addr_ch_s;
  logic [1:0]        addr_fld_s;
  logic [CNT_W-1:0]  rdata_s;
  logic [CNT_W-1:0]  rdata_r;
  logic [LFSR_W-1:0] lfsr_r;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  // Per-channel next count, wrap detect, write decode and readback mux
  always_comb begin
    addr_ch_s  = cfg_addr >> 2;
    addr_fld_s = cfg_addr[1:0];
    rdata_s    = '0;
    for (int i = 0; i < N_CH; i++) begin
      run_s[i]  = ena && (mode_r[i] != MODE_OFF);
      // >= so a PERIOD lowered under the running count wraps immediately
      wrap_s[i] = run_s[i] && (cnt_r[i] >= period_r[i]);
      if (wrap_s[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (run_s[i]) begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
      sel_s[i]       = (addr_ch_s == AW'(i));
      wr_period_s[i] = cfg_we && sel_s[i] && (addr_fld_s == F_PERIOD);
      wr_high_s[i]   = cfg_we && sel_s[i] && (addr_fld_s == F_HIGH);
      wr_mode_s[i]   = cfg_we && sel_s[i] && (addr_fld_s == F_MODE);
      tick_nxt_s[i]  = wrap_s[i] && !sync && !wr_mode_s[i];
      case (addr_fld_s)
        F_PERIOD: fld_val_s[i] = period_r[i];
        F_HIGH:   fld_val_s[i] = high_r[i];
        F_MODE:   fld_val_s[i] = {{(CNT_W-2){1'b0}}, mode_r[i]};
        default:  fld_val_s[i] = '0;
      endcase
      rdata_s = rdata_s | (sel_s[i] ? fld_val_s[i] : '0);
    end
  end

  // Channel configuration registers, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        period_r[i] <= '0;
        high_r[i]   <= '0;
        mode_r[i]   <= MODE_OFF;
        cnt_r[i]    <= '0;
      end
      div_r  <= '0;
      tick_r <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_period_s[i]) period_r[i] <= cfg_wdata;
        if (wr_high_s[i])   high_r[i]   <= cfg_wdata;
        tick_r[i] <= tick_nxt_s[i];
        if (wr_mode_s[i]) begin
          mode_r[i] <= mode_e'(cfg_wdata[1:0]);
          cnt_r[i]  <= '0;
          div_r[i]  <= 1'b0;
        end else if (!ena) begin
          // pulse output tracks tick, which is forced low while disabled
          if (mode_r[i] == MODE_PULSE) div_r[i] <= 1'b0;
        end else if (sync) begin
          cnt_r[i] <= '0;
          div_r[i] <= (mode_r[i] == MODE_DUTY) && (high_r[i] != '0);
        end else begin
          cnt_r[i] <= cnt_nxt_s[i];
          case (mode_r[i])
            MODE_TOGGLE: div_r[i] <= div_r[i] ^ wrap_s[i];
            MODE_DUTY:   div_r[i] <= (cnt_nxt_s[i] < high_r[i]);
            MODE_PULSE:  div_r[i] <= wrap_s[i];
            default:     div_r[i] <= 1'b0;
          endcase
        end
      end
    end
  end

  // Random source: load has priority, then step free-running or on channel 0 tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_SEED;
    end else if (lfsr_load) begin
      lfsr_r <= (lfsr_seed == '0) ? LFSR_SEED : lfsr_seed;
    end else if (ena && (!lfsr_mode || tick_nxt_s[0])) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  // Registered readback of the addressed field
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else begin
      rdata_r <= rdata_s;
    end
  end

  assign div_out   = div_r;
  assign tick      = tick_r;
  assign lfsr_out  = lfsr_r;
  assign cfg_rdata = rdata_r;

endmodule
